// File: rtl/seg7_scan_ctrl.sv
// Purpose: scan controller for a 4-digit common-anode 7-segment display, with blanking and frame-synchronous double buffering.
// Latency: outputs are a Moore decode of registered state; digit_en takes effect 1 cycle after it changes; a load commits at the next frame boundary.
// Backpressure: none; load is a fire-and-forget request, acknowledged once by load_ack when the staged value commits.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   value_in[15:0]   four hex digits, digit i = value_in[4i+3:4i]
//   dp_in[3:0]       decimal points, active-high
//   load             request to stage value_in/dp_in for the next frame
//   digit_en[3:0]    per-digit anode enable (registered)
//   sel[1:0]         current digit index for the external 4:1 mux
//   an[3:0]          anodes, active-low
//   seg[6:0]         segments {g,f,e,d,c,b,a}, active-low
//   dp               decimal point, active-low
//   load_ack         one-cycle pulse when staged data commits
//   frame_tick       one-cycle pulse at the start of each frame
module seg7_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 500,
   parameter int CNT_W = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic [3:0]  digit_en,
   output logic [1:0]  sel,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        load_ack,
   output logic        frame_tick
);

   // One-hot style encoding so that the two unused codes are detectable
   // and steer the machine back to a known state.
   localparam logic [1:0] ST_BLANK = 2'b01;
   localparam logic [1:0] ST_SHOW  = 2'b10;

   // With no blanking gap the BLANK state is never used, so reset lands
   // directly in SHOW of digit 0.
   localparam logic [1:0] ST_INIT = (BLANK == 0) ? ST_SHOW : ST_BLANK;

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [1:0]       sel_r;
   logic [1:0]       sel_nxt;
   logic             slot_end;
   logic             frame_start;

   logic [15:0]      staging_val;
   logic [3:0]       staging_dp;
   logic             pending;
   logic [15:0]      shadow_val;
   logic [3:0]       shadow_dp;
   logic [3:0]       digit_en_r;
   logic             load_ack_r;
   logic             frame_tick_r;

   logic [3:0]       nibble;

   // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
   function automatic logic [6:0] hex_decode(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Next-state logic. Comparisons use >= so a counter that somehow holds
   // a value past the slot end still terminates the slot immediately.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      sel_nxt   = sel_r;
      slot_end  = 1'b0;
      case (state)
         ST_BLANK: begin
            if (cnt >= BLANK_LAST) begin
               slot_end  = 1'b1;
               state_nxt = ST_SHOW;
               cnt_nxt   = '0;
            end
         end
         ST_SHOW: begin
            if (cnt >= DIV_LAST) begin
               slot_end  = 1'b1;
               state_nxt = (BLANK == 0) ? ST_SHOW : ST_BLANK;
               cnt_nxt   = '0;
               sel_nxt   = sel_r + 2'd1;
            end
         end
         default: begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            sel_nxt   = 2'd0;
         end
      endcase
   end

   // A frame starts on any slot transition that lands in SHOW of digit 0;
   // this covers both BLANK->SHOW and the SHOW->SHOW wrap of a gapless build.
   assign frame_start = slot_end && (state_nxt == ST_SHOW) && (sel_nxt == 2'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_INIT;
         cnt          <= '0;
         sel_r        <= 2'd0;
         staging_val  <= '0;
         staging_dp   <= '0;
         pending      <= 1'b0;
         shadow_val   <= '0;
         shadow_dp    <= '0;
         digit_en_r   <= '0;
         load_ack_r   <= 1'b0;
         frame_tick_r <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         sel_r        <= sel_nxt;
         digit_en_r   <= digit_en;
         frame_tick_r <= frame_start;
         load_ack_r   <= frame_start && (load || pending);

         if (load) begin
            staging_val <= value_in;
            staging_dp  <= dp_in;
         end

         if (frame_start) begin
            // A load coinciding with the boundary bypasses staging so the
            // newest value is shown this frame and nothing is left pending.
            if (load) begin
               shadow_val <= value_in;
               shadow_dp  <= dp_in;
            end else if (pending) begin
               shadow_val <= staging_val;
               shadow_dp  <= staging_dp;
            end
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   assign nibble = shadow_val[{sel_r, 2'b00} +: 4];

   // Segment and dp lines are driven for disabled digits too; only the
   // anode is gated, so the mux path behaves identically either way.
   always_comb begin
      an  = 4'hF;
      seg = 7'h7F;
      dp  = 1'b1;
      if (state == ST_SHOW) begin
         if (digit_en_r[sel_r]) begin
            an = ~(4'b0001 << sel_r);
         end
         seg = hex_decode(nibble);
         dp  = ~shadow_dp[sel_r];
      end
   end

   assign sel        = sel_r;
   assign load_ack   = load_ack_r;
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose: directed check of seg7_scan_ctrl with a blanking build and a gapless build side by side.
// Latency: expected values are per-cycle constants derived from DIV=4, BLANK=2 (frame 24) and DIV=4, BLANK=0 (frame 16).
// Backpressure: not applicable; stimulus is driven cycle by cycle.
module tb_seg7_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        load;
   logic [3:0]  digit_en;

   logic [1:0]  sel;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        load_ack;
   logic        frame_tick;

   logic [1:0]  b_sel;
   logic [3:0]  b_an;
   logic [6:0]  b_seg;
   logic        b_dp;
   logic        b_load_ack;
   logic        b_frame_tick;

   int vectors;
   int miscompares;
   int cyc;
   int b_off;

   seg7_scan_ctrl #(.DIV(4), .BLANK(2), .CNT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .load       (load),
      .digit_en   (digit_en),
      .sel        (sel),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .load_ack   (load_ack),
      .frame_tick (frame_tick)
   );

   seg7_scan_ctrl #(.DIV(4), .BLANK(0), .CNT_W(3)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .load       (load),
      .digit_en   (digit_en),
      .sel        (b_sel),
      .an         (b_an),
      .seg        (b_seg),
      .dp         (b_dp),
      .load_ack   (b_load_ack),
      .frame_tick (b_frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && cyc >= 1 && cyc <= 100 && b_an == 4'hF) b_off++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      b_off       = 0;
      rst_n       = 1'b0;
      load        = 1'b0;
      value_in    = 16'h0000;
      dp_in       = 4'h0;
      digit_en    = 4'hF;

      // Reset state
      repeat (3) tick();
      check("rst_an",   an, 4'hF);
      check("rst_sel",  sel, 2'd0);
      check("rst_seg",  seg, 7'h7F);
      check("rst_dp",   dp, 1'b1);
      check("rst_ack",  load_ack, 1'b0);
      check("rst_tick", frame_tick, 1'b0);

      rst_n = 1'b1;
      cyc   = 0;

      // Basic scan timing
      check("c0_an",   an, 4'hF);
      check("c0_sel",  sel, 2'd0);
      check("c0_seg",  seg, 7'h7F);
      check("b_c0_tick", b_frame_tick, 1'b0);
      goto(1);
      check("c1_an",   an, 4'hF);
      goto(2);
      check("c2_an",   an, 4'hE);
      check("c2_seg",  seg, 7'h40);
      check("c2_tick", frame_tick, 1'b1);
      check("c2_dp",   dp, 1'b1);

      // Load mid-frame
      goto(4);
      check("b_c4_sel", b_sel, 2'd1);
      load = 1'b1; value_in = 16'h1A3F; dp_in = 4'b0100;
      goto(5);
      load = 1'b0;
      check("c5_an", an, 4'hE);
      goto(6);
      check("c6_sel", sel, 2'd1);
      check("c6_an",  an, 4'hF);
      goto(8);
      check("c8_seg_held", seg, 7'h40);
      check("c8_an",  an, 4'hD);
      check("c8_ack", load_ack, 1'b0);
      goto(16);
      check("b_c16_ack",  b_load_ack, 1'b1);
      check("b_c16_tick", b_frame_tick, 1'b1);
      goto(25);
      check("c25_tick", frame_tick, 1'b0);
      goto(26);
      check("c26_tick", frame_tick, 1'b1);
      check("c26_ack",  load_ack, 1'b1);
      check("c26_seg",  seg, 7'h0E);
      check("c26_an",   an, 4'hE);
      check("c26_dp",   dp, 1'b1);
      goto(27);
      check("c27_ack",  load_ack, 1'b0);

      // Two loads in one frame: last wins, single ack
      goto(30);
      load = 1'b1; value_in = 16'h1111; dp_in = 4'b0000;
      goto(31);
      load = 1'b0;
      goto(32);
      check("c32_seg", seg, 7'h30);
      check("c32_dp",  dp, 1'b1);
      check("b_c32_tick", b_frame_tick, 1'b1);
      goto(35);
      load = 1'b1; value_in = 16'h2222;
      goto(36);
      load = 1'b0;
      goto(38);
      check("c38_seg", seg, 7'h08);
      check("c38_dp",  dp, 1'b0);
      goto(44);
      check("c44_seg", seg, 7'h79);
      check("c44_ack", load_ack, 1'b0);
      goto(50);
      check("c50_ack", load_ack, 1'b1);
      check("c50_seg", seg, 7'h24);
      goto(51);
      check("c51_ack", load_ack, 1'b0);
      goto(56);
      check("c56_seg", seg, 7'h24);

      // Load coincident with the frame boundary edge
      goto(73);
      load = 1'b1; value_in = 16'h00F0; dp_in = 4'b0000;
      goto(74);
      load = 1'b0;
      check("c74_ack", load_ack, 1'b1);
      check("c74_seg", seg, 7'h40);
      goto(75);
      check("c75_ack", load_ack, 1'b0);
      goto(80);
      check("c80_seg", seg, 7'h0E);
      goto(98);
      check("c98_tick", frame_tick, 1'b1);
      check("c98_ack",  load_ack, 1'b0);

      // Gapless build never darkens an enabled display
      goto(101);
      check("b_an_never_off", b_off, 0);

      // Digit enable, one cycle latency
      goto(105);
      check("c105_an", an, 4'hD);
      digit_en = 4'b0101;
      goto(106);
      check("c106_an",  an, 4'hF);
      check("c106_sel", sel, 2'd1);
      goto(110);
      check("c110_an",  an, 4'hB);
      goto(116);
      check("c116_an",  an, 4'hF);
      check("c116_seg", seg, 7'h40);
      goto(122);
      check("c122_an",  an, 4'hE);
      digit_en = 4'hF;

      // Reset in the middle of SHOW of digit 2 with a load pending
      goto(125);
      load = 1'b1; value_in = 16'h5555;
      goto(126);
      load = 1'b0;
      goto(135);
      check("c135_sel", sel, 2'd2);
      check("c135_an",  an, 4'hB);
      rst_n = 1'b0;
      tick();
      check("mrst_an",   an, 4'hF);
      check("mrst_sel",  sel, 2'd0);
      check("mrst_seg",  seg, 7'h7F);
      check("mrst_ack",  load_ack, 1'b0);
      check("b_mrst_an", b_an, 4'hF);
      check("b_mrst_sel", b_sel, 2'd0);
      rst_n = 1'b1;
      cyc   = 0;
      goto(2);
      check("r2_tick", frame_tick, 1'b1);
      check("r2_ack",  load_ack, 1'b0);
      goto(8);
      check("r8_sel",  sel, 2'd1);
      check("r8_seg",  seg, 7'h40);
      goto(26);
      check("r26_ack", load_ack, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
